track_scroller: RTL and testbench
=================================

# track_scroller

Generates and scrolls the three-lane platform track for the gravity runner. It supplies the per-lane ground-present vector `lines[2:0]` consumed by the player movement stage, with `lines[k]` sampled at the player's fixed x column. It also answers a registered per-pixel lane query for the VGA renderer. The block advances one pixel per `clk` (game tick) while `run` is high, and freezes completely when `run` is low (player dead).

## Interface
- `SEG_W`, 40 — segment width in pixels.
- `NSEG`, 17 — segments held per lane; must satisfy NSEG*SEG_W >= 640+SEG_W.
- `PLAYER_X`, 80 — screen x of the player's bottom-left corner.
- `SEED`, 16'hACE1 — LFSR reset value; 0 is replaced by 16'hACE1.

- `clk` input 1 — game tick clock.
- `reset` input 1 — synchronous, active-low.
- `run` input 1 — high: scroll and generate; low: all state held.
- `draw_x` input 10 — renderer pixel column, 0..639 valid.
- `draw_lane` input 2 — lane queried: 0 = y120, 1 = y240, 2 = y360; 3 is invalid.
- `lines` output 3 — registered; bit k = lane k solid at `PLAYER_X`.
- `draw_on` output 1 — registered; lane `draw_lane` solid at `draw_x`.
- `scroll_off` output 6 — pixel offset within the leftmost segment, 0..SEG_W-1.
- `seg_count` output 16 — segments scrolled since reset, saturating.

## Operation
- State:
  - lane registers `lane0..lane2`, NSEG bits each; bit 0 is the leftmost on-screen segment.
  - `offset` counter.
  - 16-bit Fibonacci LFSR.
  - `seg_count`.
- Reset (`reset`==0 at posedge):
  - lane0 = 0; lane1 = lane2 = all ones.
  - offset = 0; LFSR = SEED; seg_count = 0.
  - lines = 3'b110; draw_on = 0.
- Scroll, on each posedge with `run`==1:
  - If offset < SEG_W-1: offset <= offset+1.
  - If offset == SEG_W-1: offset <= 0, and a segment shift occurs.
  - Segment shift:
    - Every lane shifts toward bit 0 (bit i <= bit i+1).
    - Bit NSEG-1 takes the new column.
    - LFSR advances once.
    - seg_count increments, saturating at 16'hFFFF.
- New column uses the LFSR value before the advance:
  - lane0 <= l[1]; lane1 <= l[5]; lane2 <= l[9].
- LFSR advance:
  - fb = l[15]^l[13]^l[12]^l[10].
  - l <= {l[14:0], fb}.
- Player sample: idx_p = (PLAYER_X + offset) / SEG_W; lines[k] <= lane_k[idx_p].
- Draw query:
  - idx_d = (draw_x + offset) / SEG_W.
  - draw_on <= lane_{draw_lane}[idx_d].
  - draw_on <= 0 if draw_lane==3 or draw_x>=640.
- Arithmetic:
  - Index sums are 11 bits wide.
  - Division by the constant SEG_W may be built as a comparator chain or a constant divider.
  - idx never exceeds NSEG-1 under the parameter constraint.
- `run`==0: offset, lanes, LFSR and seg_count hold. `lines` and `draw_on` keep updating from the held state, so the renderer still works.
- Reset dominates `run`. Reset mid-shift discards the shift.

## Timing
- `lines` and `draw_on` are valid 1 cycle after the state or query they reflect.
  - Renderer latency is 1 clk from `draw_x`/`draw_lane`.
  - The value of `lines` seen by the player stage lags `offset` by 1 tick. This is acceptable at 1 px/tick.
- Segment shift cadence: exactly one shift every SEG_W run-cycles.
  - The first shift occurs on the 40th run cycle after reset.
- `scroll_off` and `seg_count` are direct register outputs with zero extra latency.
- `run` toggling mid-segment resumes counting from the held offset. No cycle is lost or double-counted.

## Configuration
- `TRACK_SAFE_COLUMN_EN` defined:
  - If the generated column is 3'b000, lane1 is forced to 1, guaranteeing every column has a surface.
  - The LFSR sequence is unaffected.
- Not defined: the column is the raw LFSR bits, and all-gap columns are possible.

## Test plan
- Reset, then hold run=0 for 100 cycles:
  - lines==3'b110, scroll_off==0, seg_count==0 throughout.
- Reset with SEED=16'hACE1, then run=1 for 40 cycles:
  - scroll_off goes 0..39..0.
  - seg_count==1.
  - lane bit NSEG-1 == {l[9],l[5],l[1]} of 16'hACE1.
  - LFSR == next state.
- run=1 for 40*NSEG cycles:
  - The first generated column reaches idx_p and appears on `lines` with 1-cycle lag.
  - Check against a software model for 2000 cycles.
- Force an LFSR state whose generated column is 0:
  - With `TRACK_SAFE_COLUMN_EN`, the new column is 3'b010.
  - Without it, the new column is 3'b000.
- Draw query sweep over draw_x 0..639 for each lane, plus draw_lane=3 and draw_x=700:
  - draw_on matches the model one cycle later.
  - The invalid queries return 0.
- Assert reset at offset==39 with run=1:
  - The next cycle shows reset values and no shift; seg_count==0.

Source files
------------

// File: rtl/track_scroller.sv
// -----------------------------------------------------------------------------
// track_scroller
//
// Generates and scrolls the three-lane platform track for the gravity runner.
// Each lane is a shift register of NSEG segment bits. Bit 0 is the leftmost
// on-screen segment. The track advances one pixel per clk while run is high.
// Every SEG_W pixels a segment shift occurs: all lanes move one segment
// toward bit 0, and a fresh column from a 16-bit Fibonacci LFSR enters at
// bit NSEG-1.
//
// Parameters:
//   SEG_W    : segment width in pixels. NSEG*SEG_W must be >= 640+SEG_W.
//   NSEG     : segments held per lane.
//   PLAYER_X : screen x of the player's bottom-left corner.
//   SEED     : LFSR reset value. A value of 0 is replaced by 16'hACE1.
//
// Ports:
//   clk        : game tick clock.
//   reset      : synchronous, active-low reset.
//   run        : 1 = scroll and generate; 0 = all track state held.
//   draw_x     : renderer pixel column. Valid range is 0..639.
//   draw_lane  : lane queried (0 = y120, 1 = y240, 2 = y360; 3 is invalid).
//   lines      : registered; bit k = lane k solid at PLAYER_X.
//   draw_on    : registered; lane draw_lane solid at draw_x.
//                Forced to 0 for draw_lane==3 or draw_x>=640.
//   scroll_off : pixel offset within the leftmost segment.
//   seg_count  : segments scrolled since reset, saturating at 16'hFFFF.
//
// Optional feature (macro TRACK_SAFE_COLUMN_EN):
//   When defined, an all-gap generated column gets lane1 forced solid.
//   The LFSR sequence is not affected.
// -----------------------------------------------------------------------------
module track_scroller #(
  parameter int          SEG_W    = 40,
  parameter int          NSEG     = 17,
  parameter int          PLAYER_X = 80,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [9:0]  draw_x,
  input  logic [1:0]  draw_lane,
  output logic [2:0]  lines,
  output logic        draw_on,
  output logic [5:0]  scroll_off,
  output logic [15:0] seg_count
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [5:0]  OFF_MAX  = 6'(SEG_W - 1);
  localparam int          IDX_W    = $clog2(NSEG);
  localparam logic [10:0] SCREEN_W = 11'd640;

  // Track state
  logic [NSEG-1:0] lane0;
  logic [NSEG-1:0] lane1;
  logic [NSEG-1:0] lane2;
  logic [5:0]      offset;
  logic [15:0]     lfsr;

  // Next LFSR state: taps 16,14,13,11, shifting toward the MSB.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    logic fb;
    fb = l[15] ^ l[13] ^ l[12] ^ l[10];
    return {l[14:0], fb};
  endfunction

  // Saturating 16-bit increment for the segment counter.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Division of an 11-bit pixel sum by the constant SEG_W.
  // This is built as a comparator chain against segment boundaries.
  function automatic logic [IDX_W-1:0] seg_index(input logic [10:0] sum);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 1; i < NSEG; i++) begin
      if (sum >= 11'(i * SEG_W)) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // Column generation: taken from the LFSR value before it advances.
  logic [2:0] raw_col;
  logic [2:0] new_col;
  logic       seg_shift;

  assign raw_col   = {lfsr[9], lfsr[5], lfsr[1]};
  assign seg_shift = run && (offset == OFF_MAX);

`ifdef TRACK_SAFE_COLUMN_EN
  // An all-gap column would be unsurvivable, so the middle lane is patched in.
  assign new_col = (raw_col == 3'b000) ? 3'b010 : raw_col;
`else
  assign new_col = raw_col;
`endif

  // ---- stage p0: index computation for player sample and renderer query ----
  logic [10:0]      sum_play_p0;
  logic [10:0]      sum_draw_p0;
  logic [IDX_W-1:0] idx_play_p0;
  logic [IDX_W-1:0] idx_draw_p0;
  logic             draw_valid_p0;
  logic             draw_bit_p0;
  logic [2:0]       lines_p0;

  assign sum_play_p0   = 11'(PLAYER_X) + {5'd0, offset};
  assign sum_draw_p0   = {1'b0, draw_x} + {5'd0, offset};
  assign idx_play_p0   = seg_index(sum_play_p0);
  assign idx_draw_p0   = seg_index(sum_draw_p0);
  assign draw_valid_p0 = (draw_lane != 2'd3) && ({1'b0, draw_x} < SCREEN_W);
  assign lines_p0      = {lane2[idx_play_p0], lane1[idx_play_p0], lane0[idx_play_p0]};

  always_comb begin
    draw_bit_p0 = 1'b0;
    case (draw_lane)
      2'd0:    draw_bit_p0 = lane0[idx_draw_p0];
      2'd1:    draw_bit_p0 = lane1[idx_draw_p0];
      2'd2:    draw_bit_p0 = lane2[idx_draw_p0];
      default: draw_bit_p0 = 1'b0;
    endcase
  end

  // ---- stage p1: registered state and outputs ----
  // Reset dominates run, so a shift pending in the same cycle is discarded.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lane0     <= '0;
      lane1     <= '1;
      lane2     <= '1;
      offset    <= '0;
      lfsr      <= SEED_EFF;
      seg_count <= '0;
      lines     <= 3'b110;
      draw_on   <= 1'b0;
    end else begin
      if (run) begin
        if (seg_shift) begin
          offset    <= '0;
          lane0     <= {new_col[0], lane0[NSEG-1:1]};
          lane1     <= {new_col[1], lane1[NSEG-1:1]};
          lane2     <= {new_col[2], lane2[NSEG-1:1]};
          lfsr      <= lfsr_next(lfsr);
          seg_count <= sat_inc(seg_count);
        end else begin
          offset <= offset + 6'd1;
        end
      end
      // The outputs keep sampling even while frozen, so the renderer still works.
      lines   <= lines_p0;
      draw_on <= draw_valid_p0 & draw_bit_p0;
    end
  end

  assign scroll_off = offset;

endmodule

// File: tb/tb_track_scroller.sv
module tb_track_scroller;
  localparam int SEG_W    = 40;
  localparam int NSEG     = 17;
  localparam int PLAYER_X = 80;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [9:0]  draw_x;
  logic [1:0]  draw_lane;
  logic [2:0]  lines;
  logic        draw_on;
  logic [5:0]  scroll_off;
  logic [15:0] seg_count;

  // Second instance seeded so its first generated column is all gaps.
  logic [9:0]  draw_x_z;
  logic [1:0]  draw_lane_z;
  logic [2:0]  lines_z;
  logic        draw_on_z;
  logic [5:0]  scroll_off_z;
  logic [15:0] seg_count_z;

  int checks = 0;
  int errors = 0;

  track_scroller #(.SEG_W(SEG_W), .NSEG(NSEG), .PLAYER_X(PLAYER_X), .SEED(16'hACE1)) dut (
    .clk(clk), .reset(reset), .run(run), .draw_x(draw_x), .draw_lane(draw_lane),
    .lines(lines), .draw_on(draw_on), .scroll_off(scroll_off), .seg_count(seg_count)
  );

  track_scroller #(.SEG_W(SEG_W), .NSEG(NSEG), .PLAYER_X(PLAYER_X), .SEED(16'h0001)) dut_z (
    .clk(clk), .reset(reset), .run(run), .draw_x(draw_x_z), .draw_lane(draw_lane_z),
    .lines(lines_z), .draw_on(draw_on_z), .scroll_off(scroll_off_z), .seg_count(seg_count_z)
  );

  always #5 clk = ~clk;

  // Reference model of the main instance
  logic [NSEG-1:0] m_lane [3];
  int              m_off;
  logic [15:0]     m_lfsr;
  logic [15:0]     m_cnt;
  logic [2:0]      m_lines;
  logic            m_draw;
  int              ip, id;
  logic [2:0]      col;

  always @(posedge clk) begin
    if (!reset) begin
      m_lane[0] = '0; m_lane[1] = '1; m_lane[2] = '1;
      m_off = 0; m_lfsr = 16'hACE1; m_cnt = 16'd0;
      m_lines = 3'b110; m_draw = 1'b0;
    end else begin
      ip = (PLAYER_X + m_off) / SEG_W;
      for (int k = 0; k < 3; k++) m_lines[k] = m_lane[k][ip];
      if (draw_lane == 2'd3 || int'(draw_x) >= 640) m_draw = 1'b0;
      else begin
        id = (int'(draw_x) + m_off) / SEG_W;
        m_draw = m_lane[draw_lane][id];
      end
      if (run) begin
        if (m_off == SEG_W - 1) begin
          m_off = 0;
          col = {m_lfsr[9], m_lfsr[5], m_lfsr[1]};
`ifdef TRACK_SAFE_COLUMN_EN
          if (col == 3'b000) col = 3'b010;
`endif
          for (int k = 0; k < 3; k++) m_lane[k] = {col[k], m_lane[k][NSEG-1:1]};
          m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else begin
          m_off = m_off + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model();
    chk("lines_m", 32'(lines), 32'(m_lines));
    chk("draw_m", 32'(draw_on), 32'(m_draw));
    chk("off_m", 32'(scroll_off), 32'(m_off));
    chk("cnt_m", 32'(seg_count), 32'(m_cnt));
  endtask

  logic [2:0] z_exp;
  bit         hit;

  initial begin
    reset = 1'b0; run = 1'b0; draw_x = 10'd0; draw_lane = 2'd0;
    draw_x_z = 10'd639; draw_lane_z = 2'd0;
    tick(); tick();
    chk("rst_lines", 32'(lines), 32'h6);
    chk("rst_draw", 32'(draw_on), 32'h0);
    chk("rst_off", 32'(scroll_off), 32'h0);
    chk("rst_cnt", 32'(seg_count), 32'h0);
    reset = 1'b1;

    // Frozen after reset. The lane1 query at x=0 is solid.
    draw_lane = 2'd1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (i % 10 == 9) begin
        chk("idle_lines", 32'(lines), 32'h6);
        chk("idle_off", 32'(scroll_off), 32'h0);
        chk("idle_cnt", 32'(seg_count), 32'h0);
        chk("idle_draw", 32'(draw_on), 32'h1);
      end
    end

    // First segment: offset runs 1..39 then wraps, and one shift occurs.
    run = 1'b1;
    for (int k = 1; k <= SEG_W; k++) begin
      tick();
      chk("scroll", 32'(scroll_off), 32'(k % SEG_W));
      chk("seg_cnt", 32'(seg_count), (k == SEG_W) ? 32'd1 : 32'd0);
    end
    chk("z_cnt", 32'(seg_count_z), 32'd1);
    tick();
    run = 1'b0;
    chk("off1", 32'(scroll_off), 32'd1);

    // New column sits at bit 16. It is visible at draw_x=639 with offset 1.
    // For seed ACE1 the column is {l9,l5,l1} = 3'b010.
    // For seed 0001 the column is all gaps.
`ifdef TRACK_SAFE_COLUMN_EN
    z_exp = 3'b010;
`else
    z_exp = 3'b000;
`endif
    draw_x = 10'd639;
    for (int k = 0; k < 3; k++) begin
      draw_lane = 2'(k); draw_lane_z = 2'(k);
      tick();
      chk("col_ace1", 32'(draw_on), (k == 1) ? 32'd1 : 32'd0);
      chk("col_zero", 32'(draw_on_z), 32'(z_exp[k]));
    end

    // Long run against the model, with random queries and occasional freezes.
    for (int i = 0; i < 2000; i++) begin
      run = (i < 800) ? 1'b1 : ($urandom_range(0, 7) != 0);
      draw_x = 10'($urandom_range(0, 700));
      draw_lane = 2'($urandom_range(0, 3));
      tick();
      chk_model();
    end

    // Frozen draw sweep over every lane and column, plus the invalid queries.
    run = 1'b0;
    for (int l = 0; l < 4; l++) begin
      for (int x = 0; x < 640; x++) begin
        draw_lane = 2'(l); draw_x = 10'(x);
        tick();
        if (x % 8 == 0 || l == 3) chk("sweep", 32'(draw_on), 32'(m_draw));
      end
    end
    draw_lane = 2'd1; draw_x = 10'd700;
    tick();
    chk("x700", 32'(draw_on), 32'h0);
    draw_lane = 2'd3; draw_x = 10'd0;
    tick();
    chk("lane3", 32'(draw_on), 32'h0);

    // Reset while a shift is pending.
    run = 1'b1; draw_lane = 2'd0;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (m_off == SEG_W - 1) hit = 1'b1;
      else tick();
    end
    chk("reach39", 32'(hit), 32'h1);
    chk("at39", 32'(scroll_off), 32'd39);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid_off", 32'(scroll_off), 32'h0);
    chk("mid_cnt", 32'(seg_count), 32'h0);
    chk("mid_lines", 32'(lines), 32'h6);
    chk("mid_draw", 32'(draw_on), 32'h0);
    for (int i = 0; i < 60; i++) begin
      tick();
      chk_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
